// File: rtl/panda_controller.sv
// Pipeline controller for the Panda RV32I core: boot, PC redirect, stall, flush, halt, retire count.
// Latency: all control outputs are Mealy (state + current inputs), no added cycles; instret_o updates on the retiring edge.
// Backpressure: a data request without grant stalls IF/ID and is held; a load waits in LSU_WAIT with IF/ID stalled.
module panda_controller #(
    parameter int unsigned FLUSH_CYCLES = 1,   // cycles id_flush_o stays high after a redirect, 1..7
    parameter int unsigned CNT_W        = 64   // width of the retired-instruction counter
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic             id_illegal_i,
    input  logic             ex_valid_i,
    input  logic             ex_jump_i,
    input  logic             ex_branch_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_mem_i,
    input  logic             ex_store_i,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    output logic             data_req_o,
    output logic             pc_set_o,
    output logic             pc_sel_o,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             id_flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_BOOT     = 3'd1,
        S_RUN      = 3'd2,
        S_LSU_WAIT = 3'd3,
        S_FLUSH    = 3'd4,
        S_HALT     = 3'd5
    } state_e;

    // The redirect cycle itself flushes once; the FLUSH state covers the remaining cycles.
    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    localparam logic PC_SEL_BOOT   = 1'b0;
    localparam logic PC_SEL_TARGET = 1'b1;

    state_e           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic redirect;
    logic ex_mem_op;
    logic id_illegal;
    logic retire;

    // Qualified decode of the EX/ID flags used by the RUN priority chain
    always_comb begin
        redirect   = ex_valid_i & (ex_jump_i | (ex_branch_i & ex_branch_taken_i));
        ex_mem_op  = ex_valid_i & ex_mem_i;
        id_illegal = id_valid_i & id_illegal_i;
    end

    // Next-state, Mealy outputs and retire strobe
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        data_req_o  = 1'b0;
        pc_set_o    = 1'b0;
        pc_sel_o    = PC_SEL_BOOT;
        if_stall_o  = 1'b0;
        id_stall_o  = 1'b0;
        id_flush_o  = 1'b0;
        halted_o    = 1'b0;
        retire      = 1'b0;

        unique case (state_q)
            S_RESET: begin
                if_stall_o = 1'b1;
                id_stall_o = 1'b1;
                state_d    = S_BOOT;
            end

            S_BOOT: begin
                pc_set_o   = 1'b1;
                pc_sel_o   = PC_SEL_BOOT;
                id_flush_o = 1'b1;
                state_d    = S_RUN;
            end

            S_RUN: begin
                if (redirect) begin
                    // Redirect outranks everything, so a wrong-path illegal in ID never halts.
                    pc_set_o   = 1'b1;
                    pc_sel_o   = PC_SEL_TARGET;
                    id_flush_o = 1'b1;
                    retire     = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else if (ex_mem_op) begin
                    data_req_o = 1'b1;
                    if (!data_gnt_i) begin
                        // Request held until granted; pipeline frozen meanwhile.
                        if_stall_o = 1'b1;
                        id_stall_o = 1'b1;
                    end else if (ex_store_i) begin
                        retire = 1'b1;
                    end else if (data_rvalid_i) begin
                        // Grant and data in the same cycle: single-cycle load.
                        retire = 1'b1;
                    end else begin
                        if_stall_o = 1'b1;
                        id_stall_o = 1'b1;
                        state_d    = S_LSU_WAIT;
                    end
                end else if (id_illegal) begin
                    // Let the older EX instruction complete, squash the illegal one and stop fetch.
                    id_flush_o = 1'b1;
                    if_stall_o = 1'b1;
                    retire     = ex_valid_i;
                    state_d    = S_HALT;
                end else begin
                    retire = ex_valid_i;
                end
            end

            S_LSU_WAIT: begin
                if (data_rvalid_i) begin
                    retire  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    if_stall_o = 1'b1;
                    id_stall_o = 1'b1;
                end
            end

            S_FLUSH: begin
                // EX only holds bubbles here, so no redirect or retire; ID illegal is wrong-path.
                id_flush_o  = 1'b1;
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q == 3'd1) begin
                    state_d = S_RUN;
                end
            end

            S_HALT: begin
                halted_o   = 1'b1;
                if_stall_o = 1'b1;
                id_stall_o = 1'b1;
                id_flush_o = 1'b1;
            end

            default: begin
                if_stall_o = 1'b1;
                id_stall_o = 1'b1;
                state_d    = S_RESET;
            end
        endcase
    end

    // Retired-instruction counter wraps naturally at 2^CNT_W
    always_comb begin
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // State, flush counter and instret registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RESET;
            flush_cnt_q <= 3'd0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            instret_q   <= instret_d;
        end
    end

    assign instret_o = instret_q;

endmodule

// File: tb/tb_panda_controller.sv
// Directed bench for panda_controller: one instance with FLUSH_CYCLES=3/CNT_W=4, one with defaults.
// Both share stimulus; control outputs and instret are compared against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_panda_controller;

    logic clk;
    logic rst_ni;
    logic id_valid, id_illegal, ex_valid, ex_jump, ex_branch, ex_taken;
    logic ex_mem, ex_store, data_gnt, data_rvalid;

    logic a_data_req, a_pc_set, a_pc_sel, a_if_stall, a_id_stall, a_id_flush, a_halted;
    logic b_data_req, b_pc_set, b_pc_sel, b_if_stall, b_id_stall, b_id_flush, b_halted;
    logic [3:0]  a_instret;
    logic [63:0] b_instret;

    logic [6:0] outs_a, outs_b;
    assign outs_a = {a_data_req, a_pc_set, a_pc_sel, a_if_stall, a_id_stall, a_id_flush, a_halted};
    assign outs_b = {b_data_req, b_pc_set, b_pc_sel, b_if_stall, b_id_stall, b_id_flush, b_halted};

    // Output vector order: data_req, pc_set, pc_sel, if_stall, id_stall, id_flush, halted
    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_RESET  = 7'b0001100;
    localparam logic [6:0] O_BOOT   = 7'b0100010;
    localparam logic [6:0] O_REDIR  = 7'b0110010;
    localparam logic [6:0] O_FLUSH  = 7'b0000010;
    localparam logic [6:0] O_REQSTL = 7'b1001100;
    localparam logic [6:0] O_REQOK  = 7'b1000000;
    localparam logic [6:0] O_WAIT   = 7'b0001100;
    localparam logic [6:0] O_ILL    = 7'b0001010;
    localparam logic [6:0] O_HALT   = 7'b0001111;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    panda_controller #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_valid_i(id_valid), .id_illegal_i(id_illegal),
        .ex_valid_i(ex_valid), .ex_jump_i(ex_jump), .ex_branch_i(ex_branch),
        .ex_branch_taken_i(ex_taken), .ex_mem_i(ex_mem), .ex_store_i(ex_store),
        .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_req_o(a_data_req), .pc_set_o(a_pc_set), .pc_sel_o(a_pc_sel),
        .if_stall_o(a_if_stall), .id_stall_o(a_id_stall), .id_flush_o(a_id_flush),
        .halted_o(a_halted), .instret_o(a_instret)
    );

    panda_controller dut_b (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_valid_i(id_valid), .id_illegal_i(id_illegal),
        .ex_valid_i(ex_valid), .ex_jump_i(ex_jump), .ex_branch_i(ex_branch),
        .ex_branch_taken_i(ex_taken), .ex_mem_i(ex_mem), .ex_store_i(ex_store),
        .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_req_o(b_data_req), .pc_set_o(b_pc_set), .pc_sel_o(b_pc_sel),
        .if_stall_o(b_if_stall), .id_stall_o(b_id_stall), .id_flush_o(b_id_flush),
        .halted_o(b_halted), .instret_o(b_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Both instances expected to show the same outputs
    task automatic chk_both(input string tag, input logic [6:0] exp);
        #1;
        chk({tag, "_a"}, 64'(outs_a), 64'(exp));
        chk({tag, "_b"}, 64'(outs_b), 64'(exp));
    endtask

    task automatic chk_ab(input string tag, input logic [6:0] exp_a, input logic [6:0] exp_b);
        #1;
        chk({tag, "_a"}, 64'(outs_a), 64'(exp_a));
        chk({tag, "_b"}, 64'(outs_b), 64'(exp_b));
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt_a"}, 64'(a_instret), 64'(exp_cnt % 16));
        chk({tag, "_cnt_b"}, 64'(b_instret), 64'(exp_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_illegal = 0; ex_valid = 0; ex_jump = 0; ex_branch = 0;
        ex_taken = 0; ex_mem = 0; ex_store = 0; data_gnt = 0; data_rvalid = 0;
    endtask

    initial begin
        clr();
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;

        // ---- reset state and boot sequence ----
        chk_both("in_reset", O_RESET);
        chk_cnt("in_reset");
        tick(); tick();
        rst_ni = 1'b1;
        chk_both("reset_cycle", O_RESET);
        tick();
        chk_both("boot", O_BOOT);
        tick();
        chk_both("run_idle", O_IDLE);
        chk_cnt("after_boot");

        // ---- taken branch: a flushes 3 cycles, b only 1 ----
        ex_valid = 1; ex_branch = 1; ex_taken = 1;
        chk_both("br_taken", O_REDIR);
        tick(); exp_cnt++;
        clr();
        chk_ab("flush1", O_FLUSH, O_IDLE);
        chk_cnt("br_taken");
        tick();
        chk_ab("flush2", O_FLUSH, O_IDLE);
        tick();
        chk_both("flush_done", O_IDLE);

        // not-taken branch retires without redirect
        ex_valid = 1; ex_branch = 1; ex_taken = 0;
        chk_both("br_not_taken", O_IDLE);
        tick(); exp_cnt++;
        clr();
        chk_cnt("br_not_taken");

        // ---- load: gnt after 2 cycles, rvalid 3 cycles after gnt ----
        ex_valid = 1; ex_mem = 1; ex_store = 0;
        chk_both("ld_nogнт0", O_REQSTL);
        tick();
        chk_both("ld_nognt1", O_REQSTL);
        tick();
        data_gnt = 1;
        chk_both("ld_gnt", O_REQSTL);
        tick();
        data_gnt = 0;
        chk_both("ld_wait1", O_WAIT);
        tick();
        chk_both("ld_wait2", O_WAIT);
        chk_cnt("ld_wait2");
        tick();
        data_rvalid = 1;
        chk_both("ld_rvalid", O_IDLE);
        tick(); exp_cnt++;
        clr();
        chk_cnt("ld_done");

        // store granted immediately retires with no stall
        ex_valid = 1; ex_mem = 1; ex_store = 1; data_gnt = 1;
        chk_both("st_gnt", O_REQOK);
        tick(); exp_cnt++;
        clr();

        // single-cycle load: gnt and rvalid together, stays in RUN
        ex_valid = 1; ex_mem = 1; data_gnt = 1; data_rvalid = 1;
        chk_both("ld_1cyc", O_REQOK);
        tick(); exp_cnt++;
        clr();
        chk_both("ld_1cyc_after", O_IDLE);
        chk_cnt("ld_1cyc");

        // ---- illegal in ID alongside taken jump: redirect wins ----
        ex_valid = 1; ex_jump = 1; id_valid = 1; id_illegal = 1;
        chk_both("jmp_ill", O_REDIR);
        tick(); exp_cnt++;
        clr();
        chk_ab("jmp_ill_f1", O_FLUSH, O_IDLE);
        tick();
        chk_ab("jmp_ill_f2", O_FLUSH, O_IDLE);
        tick();
        chk_both("jmp_ill_run", O_IDLE);
        chk_cnt("jmp_ill");

        // ---- correct-path illegal with an older ALU op in EX ----
        ex_valid = 1; id_valid = 1; id_illegal = 1;
        chk_both("ill", O_ILL);
        tick(); exp_cnt++;
        clr();
        chk_both("halt1", O_HALT);
        chk_cnt("ill");
        ex_valid = 1; ex_jump = 1;
        chk_both("halt_jmp", O_HALT);
        tick(); tick();
        chk_both("halt_held", O_HALT);
        chk_cnt("halt_held");
        clr();

        // ---- reset during LSU_WAIT, late rvalid ignored ----
        rst_ni = 0;
        exp_cnt = 0;
        chk_both("rst_from_halt", O_RESET);
        chk_cnt("rst_from_halt");
        tick();
        rst_ni = 1;
        tick(); tick();
        ex_valid = 1; ex_mem = 1; data_gnt = 1;
        chk_both("ld2_gnt", O_REQSTL);
        tick();
        clr();
        ex_valid = 1; ex_mem = 1;
        chk_both("ld2_wait", O_WAIT);
        rst_ni = 0;
        clr();
        chk_both("rst_in_wait", O_RESET);
        chk_cnt("rst_in_wait");
        tick();
        rst_ni = 1;
        chk_both("rst2_cycle", O_RESET);
        tick();
        data_rvalid = 1;
        chk_both("late_rvalid_boot", O_BOOT);
        tick();
        clr();
        chk_both("late_rvalid_run", O_IDLE);
        chk_cnt("late_rvalid");

        // ---- 17 back-to-back ALU retirements: 4-bit counter wraps to 1 ----
        ex_valid = 1;
        for (int i = 0; i < 15; i++) begin
            tick(); exp_cnt++;
        end
        chk_cnt("cnt15");
        tick(); exp_cnt++;
        chk_cnt("cnt16_wrap");
        tick(); exp_cnt++;
        chk_cnt("cnt17");
        chk("cnt17_a_is_1", 64'(a_instret), 64'd1);
        clr();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
